fifo_loader: RTL and testbench
==============================

// Module: fifo_loader
// PURPOSE
//  Upstream feeder for the weight/input FIFO buffer. On start, streams Length words from a
//  synchronous-read on-chip memory, from BaseAddr upward, into the FIFO Push/DataIn interface.
//  Honours FIFO Full with a 2-entry holding buffer so no word is lost or reordered.
//  Sustains 1 word/cycle while Full is low. Reports Busy and a one-cycle Done pulse.
// PARAMETERS
//  DataWidth  32  width of memory words and FIFO data
//  AddrWidth  10  memory address width; addresses wrap modulo 2^AddrWidth
//  LenWidth   10  width of Length; max transfer is 2^LenWidth-1 words
// PORTS
//  clk       in   1          clock, rising edge
//  aclr      in   1          reset, asynchronous, active-high
//  Start     in   1          request transfer; sampled only in IDLE
//  BaseAddr  in   AddrWidth  first memory address, captured with Start
//  Length    in   LenWidth   words to transfer, captured with Start
//  MemRd     out  1          memory read enable
//  MemAddr   out  AddrWidth  memory read address
//  MemRData  in   DataWidth  read data, valid exactly one cycle after MemRd
//  FifoFull  in   1          FIFO Full flag
//  FifoPush  out  1          FIFO Push
//  FifoData  out  DataWidth  FIFO DataIn
//  Busy      out  1          high from cycle after accepted Start until Done cycle inclusive
//  Done      out  1          one-cycle pulse: transfer complete
// BEHAVIOUR
//  Reset (aclr high, any time incl. mid-transfer): state IDLE; MemRd=0, MemAddr=0, FifoPush=0,
//   FifoData=0, Busy=0, Done=0; hold buffer, counters and in-flight flag cleared. No push after.
//  States: IDLE -> RUN on Start (Length!=0); IDLE -> DONE on Start with Length==0;
//   RUN -> DONE when pushed count reaches Length; DONE -> IDLE unconditionally.
//  Start in RUN/DONE is ignored; BaseAddr/Length changes after capture have no effect.
//  Read issue (RUN): credit = 2 - HoldCnt - InFlight + FifoPush. MemRd=1 when credit>=1 and
//   issued count < Length. MemAddr = BaseAddr + issued count (mod 2^AddrWidth); registered.
//  InFlight = MemRd of previous cycle. MemRData captured into hold buffer (2-entry FIFO) on the
//   edge ending the cycle after MemRd.
//  Push: FifoPush = (HoldCnt!=0) & ~FifoFull (combinational); FifoData = hold head (0 when empty).
//   Pop of hold head on the same edge. Simultaneous capture and pop allowed; HoldCnt never > 2.
//  Latency: Start sampled on edge E0 -> first MemRd in cycle after E0 -> first FifoPush two
//   cycles later (3 cycles after E0) if FifoFull low. Then one push per cycle.
//  FifoFull high: pushes stall; at most 2 words held + 0 in flight once steady; resume on the
//   first cycle FifoFull is low, in address order.
//  Done: asserted in DONE state, one cycle after the edge of the final push; Busy low next cycle.
//  Length==0: Done pulses the cycle after Start edge; no MemRd, no FifoPush.
// TESTING
//  T1 Base=0x010, Len=4, Full=0, mem[a]=a -> MemRd addrs 0x010..0x013 on consecutive cycles;
//     FifoPush 4 consecutive cycles, data 0x10,0x11,0x12,0x13; Done one cycle after last push.
//  T2 Len=8, FifoFull forced high 5 cycles after 2nd push -> no push while Full, never >2 held,
//     all 8 words arrive exactly once in order; Done after 8th push.
//  T3 Base=1022, Len=4, AddrWidth=10 -> MemAddr 1022,1023,0,1; data order matches.
//  T4 Len=0 -> Done pulse next cycle, Busy stays 0, no MemRd/FifoPush.
//  T5 Start pulsed again mid-transfer with new Base/Len -> ignored; original 6-word transfer
//     completes unchanged; new Start after Done returns to IDLE is accepted.
//  T6 aclr raised asynchronously mid-transfer (3 of 8 pushed) -> all outputs 0 immediately,
//     no further push; fresh Start afterward runs a clean full transfer.

Source files
------------

// File: rtl/fifo_loader_if.sv
// Handshake bundle between the FIFO loader, its source memory and the target FIFO.
// The master side is the loader itself; the slave side is whatever drives the
// control inputs, serves the memory reads and owns the FIFO.
interface fifo_loader_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 10,
    parameter int LenWidth  = 10
);
    logic                 Start;
    logic [AddrWidth-1:0] BaseAddr;
    logic [LenWidth-1:0]  Length;
    logic                 MemRd;
    logic [AddrWidth-1:0] MemAddr;
    logic [DataWidth-1:0] MemRData;
    logic                 FifoFull;
    logic                 FifoPush;
    logic [DataWidth-1:0] FifoData;
    logic                 Busy;
    logic                 Done;

    modport master (
        input  Start, BaseAddr, Length, MemRData, FifoFull,
        output MemRd, MemAddr, FifoPush, FifoData, Busy, Done
    );

    modport slave (
        output Start, BaseAddr, Length, MemRData, FifoFull,
        input  MemRd, MemAddr, FifoPush, FifoData, Busy, Done
    );
endinterface

// File: rtl/fifo_loader.sv
// Streams Length words from a synchronous-read memory, starting at BaseAddr, into a
// FIFO push port. A 2-entry holding buffer absorbs the one-cycle memory latency so
// that FifoFull can stall the stream without losing or reordering words, while still
// sustaining one word per cycle when the FIFO has room.
module fifo_loader #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 10,
    parameter int LenWidth  = 10
) (
    input  logic         clk,
    input  logic         aclr,
    fifo_loader_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [AddrWidth-1:0] addr_q;
    logic [LenWidth-1:0]  len_q;
    logic [LenWidth-1:0]  issued_q;
    logic [LenWidth-1:0]  pushed_q;
    logic                 inflight_q;
    logic [DataWidth-1:0] hold_q [2];
    logic [1:0]           hold_cnt_q;

    logic                 load;
    logic                 rd;
    logic                 push;
    logic                 credit_ok;
    logic                 busy;
    logic                 done;

    // A read may be issued only if the word it returns is guaranteed a hold slot:
    // slots in use (held + in flight) must stay below 2, plus one freed by this cycle's push.
    assign push      = (hold_cnt_q != 2'd0) && !bus.FifoFull;
    assign credit_ok = ({1'b0, hold_cnt_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, push});

    // State register.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus read-issue, Busy and Done generation.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        rd      = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    load    = 1'b1;
                    state_d = (bus.Length == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                rd   = credit_ok && (issued_q != len_q);
                if (push && ((pushed_q + LenWidth'(1)) == len_q)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // A zero-length request never reports Busy, only the Done pulse.
                busy    = (len_q != '0);
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Transfer bookkeeping: captured request, read address, issue/push counters.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            pushed_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= rd;
            if (load) begin
                addr_q   <= bus.BaseAddr;
                len_q    <= bus.Length;
                issued_q <= '0;
                pushed_q <= '0;
            end else begin
                if (rd) begin
                    addr_q   <= addr_q + AddrWidth'(1);
                    issued_q <= issued_q + LenWidth'(1);
                end
                if (push) begin
                    pushed_q <= pushed_q + LenWidth'(1);
                end
            end
        end
    end

    // Holding buffer: returning read data enters at the tail, the FIFO drains the head.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            hold_q[0]  <= '0;
            hold_q[1]  <= '0;
            hold_cnt_q <= 2'd0;
        end else begin
            case ({inflight_q, push})
                2'b10: begin
                    hold_q[hold_cnt_q[0]] <= bus.MemRData;
                    hold_cnt_q            <= hold_cnt_q + 2'd1;
                end
                2'b01: begin
                    hold_q[0]  <= hold_q[1];
                    hold_cnt_q <= hold_cnt_q - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new word lands behind whatever remains.
                    if (hold_cnt_q == 2'd1) begin
                        hold_q[0] <= bus.MemRData;
                    end else begin
                        hold_q[0] <= hold_q[1];
                        hold_q[1] <= bus.MemRData;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.MemRd    = rd;
    assign bus.MemAddr  = addr_q;
    assign bus.FifoPush = push;
    assign bus.FifoData = (hold_cnt_q != 2'd0) ? hold_q[0] : '0;
    assign bus.Busy     = busy;
    assign bus.Done     = done;
endmodule

// File: tb/tb_fifo_loader.sv
// Directed bench for fifo_loader. The memory model returns mem[a] = a one cycle after
// a read; a negedge monitor logs reads, pushes, Done pulses and Busy cycles, and each
// test compares those logs with hand-derived addresses, data and cycle numbers.
module tb_fifo_loader;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int LW = 10;

    logic clk  = 1'b0;
    logic aclr = 1'b1;

    fifo_loader_if #(.DataWidth(DW), .AddrWidth(AW), .LenWidth(LW)) bus ();

    fifo_loader #(.DataWidth(DW), .AddrWidth(AW), .LenWidth(LW)) dut (
        .clk  (clk),
        .aclr (aclr),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // mem[a] = a, read data valid the cycle after MemRd; junk otherwise.
    always @(posedge clk) bus.MemRData <= bus.MemRd ? DW'(bus.MemAddr) : 32'hDEAD_BEEF;

    logic [31:0] rd_addr[$];
    int          rd_cyc[$];
    logic [31:0] pu_data[$];
    int          pu_cyc[$];
    int          dn_cyc[$];
    int busy_cnt   = 0;
    int pend       = 0;
    int full_run   = 0;
    int v_pushfull = 0;
    int v_rdfull   = 0;
    int v_pend     = 0;

    int vec_cnt = 0;
    int err_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (aclr) begin
                pend     = 0;
                full_run = 0;
            end else begin
                full_run = bus.FifoFull ? full_run + 1 : 0;
                if (bus.FifoPush && bus.FifoFull) v_pushfull++;
                if (bus.MemRd && full_run >= 2) v_rdfull++;
                if (full_run >= 2 && pend > 2) v_pend++;
                if (bus.MemRd) begin
                    rd_addr.push_back(32'(bus.MemAddr));
                    rd_cyc.push_back(cyc);
                end
                if (bus.FifoPush) begin
                    pu_data.push_back(bus.FifoData);
                    pu_cyc.push_back(cyc);
                end
                if (bus.Done) dn_cyc.push_back(cyc);
                if (bus.Busy) busy_cnt++;
                pend = pend + int'(bus.MemRd) - int'(bus.FifoPush);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_xfer(input int base, input int len, output int s);
        tick();
        bus.Start    = 1'b1;
        bus.BaseAddr = AW'(base);
        bus.Length   = LW'(len);
        @(posedge clk);
        #1;
        s = cyc;
        bus.Start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n0 = dn_cyc.size();
        int n  = 0;
        while (dn_cyc.size() == n0 && n < budget) begin
            tick();
            n++;
        end
        check({tag, " done seen"}, 32'(dn_cyc.size() > n0), 32'd1);
        tick();
        tick();
    endtask

    task automatic wait_pushes(input string tag, input int pu0, input int target);
        int n = 0;
        while (pu_data.size() - pu0 < target && n < 50) begin
            tick();
            n++;
        end
        check({tag, " pushes reached"}, 32'(pu_data.size() - pu0), 32'(target));
    endtask

    task automatic verify(input string tag, input int base, input int len,
                          input int rd0, input int pu0, input int s, input bit timed);
        logic [31:0] exp;
        check({tag, " read count"}, 32'(rd_addr.size() - rd0), 32'(len));
        check({tag, " push count"}, 32'(pu_data.size() - pu0), 32'(len));
        for (int i = 0; i < len; i++) begin
            exp = 32'((base + i) & ((1 << AW) - 1));
            if (rd0 + i < rd_addr.size()) begin
                check($sformatf("%s addr%0d", tag, i), rd_addr[rd0 + i], exp);
                if (timed) check($sformatf("%s rdcyc%0d", tag, i), 32'(rd_cyc[rd0 + i] - s), 32'(i));
            end
            if (pu0 + i < pu_data.size()) begin
                check($sformatf("%s data%0d", tag, i), pu_data[pu0 + i], exp);
                if (timed) check($sformatf("%s pucyc%0d", tag, i), 32'(pu_cyc[pu0 + i] - s), 32'(i + 2));
            end
        end
        if (len > 0 && pu_data.size() > pu0 && dn_cyc.size() > 0)
            check({tag, " done after last push"}, 32'(dn_cyc[dn_cyc.size() - 1] - pu_cyc[pu_cyc.size() - 1]), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s, s2, rd0, pu0, dn0, b0;
        bus.Start    = 1'b0;
        bus.BaseAddr = '0;
        bus.Length   = '0;
        bus.FifoFull = 1'b0;
        aclr         = 1'b1;
        tick();
        tick();
        check("rst MemRd",    32'(bus.MemRd),    32'd0);
        check("rst MemAddr",  32'(bus.MemAddr),  32'd0);
        check("rst FifoPush", 32'(bus.FifoPush), 32'd0);
        check("rst FifoData", bus.FifoData,      32'd0);
        check("rst Busy",     32'(bus.Busy),     32'd0);
        check("rst Done",     32'(bus.Done),     32'd0);
        aclr = 1'b0;
        tick();

        // T1: basic 4-word stream at full rate
        rd0 = rd_addr.size(); pu0 = pu_data.size(); dn0 = dn_cyc.size(); b0 = busy_cnt;
        start_xfer(32'h010, 4, s);
        wait_done("T1", 40);
        verify("T1", 32'h010, 4, rd0, pu0, s, 1'b1);
        check("T1 done cycle", 32'(dn_cyc[dn_cyc.size() - 1] - s), 32'd6);
        check("T1 done pulses", 32'(dn_cyc.size() - dn0), 32'd1);
        check("T1 busy cycles", 32'(busy_cnt - b0), 32'd7);

        // T2: FIFO full for 5 cycles right after the second push
        rd0 = rd_addr.size(); pu0 = pu_data.size(); dn0 = dn_cyc.size();
        start_xfer(32'h100, 8, s);
        wait_pushes("T2", pu0, 2);
        @(posedge clk);
        #1;
        bus.FifoFull = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.FifoFull = 1'b0;
        wait_done("T2", 60);
        verify("T2", 32'h100, 8, rd0, pu0, s, 1'b0);
        if (pu_data.size() - pu0 >= 8)
            check("T2 push span", 32'(pu_cyc[pu0 + 7] - pu_cyc[pu0]), 32'd12);
        check("T2 push while full", 32'(v_pushfull), 32'd0);
        check("T2 read while full", 32'(v_rdfull), 32'd0);
        check("T2 held > 2", 32'(v_pend), 32'd0);
        check("T2 done pulses", 32'(dn_cyc.size() - dn0), 32'd1);

        // T3: address wrap
        rd0 = rd_addr.size(); pu0 = pu_data.size();
        start_xfer(1022, 4, s);
        wait_done("T3", 40);
        verify("T3", 1022, 4, rd0, pu0, s, 1'b1);

        // T4: zero length
        rd0 = rd_addr.size(); pu0 = pu_data.size(); dn0 = dn_cyc.size(); b0 = busy_cnt;
        start_xfer(5, 0, s);
        tick();
        check("T4 done pulses", 32'(dn_cyc.size() - dn0), 32'd1);
        if (dn_cyc.size() > dn0) check("T4 done cycle", 32'(dn_cyc[dn0] - s), 32'd0);
        repeat (4) tick();
        check("T4 done once", 32'(dn_cyc.size() - dn0), 32'd1);
        check("T4 busy cycles", 32'(busy_cnt - b0), 32'd0);
        check("T4 reads", 32'(rd_addr.size() - rd0), 32'd0);
        check("T4 pushes", 32'(pu_data.size() - pu0), 32'd0);

        // T5: Start during a transfer is ignored, accepted again afterwards
        rd0 = rd_addr.size(); pu0 = pu_data.size(); dn0 = dn_cyc.size();
        start_xfer(32'h040, 6, s);
        tick();
        bus.Start    = 1'b1;
        bus.BaseAddr = AW'(32'h200);
        bus.Length   = LW'(3);
        tick();
        bus.Start = 1'b0;
        wait_done("T5a", 40);
        verify("T5a", 32'h040, 6, rd0, pu0, s, 1'b1);
        check("T5a done pulses", 32'(dn_cyc.size() - dn0), 32'd1);
        rd0 = rd_addr.size(); pu0 = pu_data.size();
        start_xfer(32'h080, 2, s2);
        wait_done("T5b", 40);
        verify("T5b", 32'h080, 2, rd0, pu0, s2, 1'b1);

        // T6: asynchronous reset mid-transfer, then a clean rerun
        pu0 = pu_data.size();
        start_xfer(32'h300, 8, s);
        wait_pushes("T6", pu0, 3);
        #1;
        aclr = 1'b1;
        #1;
        check("T6 async MemRd",    32'(bus.MemRd),    32'd0);
        check("T6 async MemAddr",  32'(bus.MemAddr),  32'd0);
        check("T6 async FifoPush", 32'(bus.FifoPush), 32'd0);
        check("T6 async FifoData", bus.FifoData,      32'd0);
        check("T6 async Busy",     32'(bus.Busy),     32'd0);
        check("T6 async Done",     32'(bus.Done),     32'd0);
        tick();
        aclr = 1'b0;
        rd0 = rd_addr.size(); pu0 = pu_data.size(); dn0 = dn_cyc.size();
        repeat (5) tick();
        check("T6 no push after reset", 32'(pu_data.size() - pu0), 32'd0);
        check("T6 no read after reset", 32'(rd_addr.size() - rd0), 32'd0);
        check("T6 no done after reset", 32'(dn_cyc.size() - dn0), 32'd0);
        start_xfer(32'h300, 8, s);
        wait_done("T6r", 40);
        verify("T6r", 32'h300, 8, rd0, pu0, s, 1'b1);

        check("end push while full", 32'(v_pushfull), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
